operand_fetch: RTL and testbench
================================

# operand_fetch

Decode-to-execute operand stage of the pipelined RISC-V core and the read-side client of the register file. It drives the two register-file read addresses and takes the returned values. It resolves RAW hazards by bypassing from the MEM and WB stages and stalling on load-use. It presents operands to execute through a registered valid/ready pipeline slot.

## Interface
- N, 32, data width of registers, immediates and operands
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  decode holds an instruction
- id_ready  out  1  this stage accepts it this cycle
- id_rs1, id_rs2  in  5  source register indices
- id_rd  in  5  destination index
- id_regwrite, id_memread  in  1  writes rd; is a load
- id_imm  in  N  decoded immediate
- rf_src1, rf_src2  out  5  register-file read addresses
- rf_out1, rf_out2  in  N  register-file read data (combinational)
- mem_rd, mem_regwrite, mem_data  in  5/1/N  MEM-stage result
- wb_rd, wb_regwrite, wb_data  in  5/1/N  WB-stage result; same bus that writes the register file
- flush  in  1  branch/jump squash of the slot
- ex_valid  out  1  slot holds a valid instruction
- ex_ready  in  1  execute consumes the slot
- ex_op1, ex_op2, ex_imm  out  N  resolved operands, immediate
- ex_rd, ex_regwrite, ex_memread  out  5/1/1  forwarded control

## Operation
- rf_src1/rf_src2 = id_rs1/id_rs2 combinationally, every cycle.
- Per-operand select, priority high→low:
  - index 0 → 0
  - mem_regwrite && mem_rd==idx → mem_data
  - wb_regwrite && wb_rd==idx → wb_data
  - else rf_out.
- WB bypass is mandatory: the register file writes on the same edge this stage samples, so the combinational read is stale.
- Load-use hazard: ex_valid && ex_memread && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2) while id_valid.
- advance = !ex_valid || ex_ready. id_ready = advance && !hazard.
- State machine (FSM) with two states:
  - RUN: on advance, the slot loads the id_* fields with ex_valid=id_valid. If hazard && advance, the slot loads a bubble (ex_valid=0) and goes to STALL. If !advance, the slot holds.
  - STALL: one cycle; the load has moved to MEM, so its result is now bypassed. Return to RUN with a normal accept.
- flush (highest priority): the next edge clears ex_valid, returns to RUN, and id_ready=0 that cycle. flush+hazard in the same cycle → flush wins.
- ex_rd is forced to 0 and ex_regwrite/ex_memread to 0 whenever a bubble is loaded.

## Timing
- Reset (rst low, asynchronous): ex_valid=0, ex_op1=ex_op2=ex_imm=0, ex_rd=0, ex_regwrite=ex_memread=0, FSM=RUN.
- Latency: one cycle from an accepted ID beat to ex_valid.
- Load-use costs exactly one bubble cycle; no other hazard stalls when forwarding is compiled in.
- When ex_valid && !ex_ready, all ex_* outputs are held stable; id_ready=0.
- Reset mid-stall drops the pending instruction; decode must re-present it.

## Configuration
- OPERAND_FETCH_FWD_EN defined: MEM/WB bypass and single-bubble load-use as above.
- Undefined: operands come only from rf_out, with the mandatory WB bypass kept. Full interlock applies: hazard = id source (nonzero) matches a valid regwrite rd in the EX slot or MEM. Stall repeats until the hazard clears; each stall cycle loads a bubble. The STALL state is unused.

## Structure
- Shared package riscv_pkg holds:
  - REG_ADDR_W=5
  - REG_ZERO=5'd0
  - typedef fwd_sel_t {FWD_RF, FWD_MEM, FWD_WB, FWD_ZERO}
  - typedef of_state_t {OF_RUN, OF_STALL}
- Sub-module operand_bypass_mux computes the per-operand select and value. It is instantiated twice (rs1, rs2).

## Test plan
- Reset, then id rs1=3 rs2=4 with rf_out1=0x11 and rf_out2=0x22 → next cycle ex_valid=1, ex_op1=0x11, ex_op2=0x22.
- mem_rd=5 and wb_rd=5 both writing (mem_data=0xAA, wb_data=0xBB) with id_rs1=5 → ex_op1=0xAA. Repeat with only WB → 0xBB. With rs1=0 and mem_rd=0 → 0.
- Load rd=7 in the slot, next id rs2=7 → id_ready=0 for one cycle and a bubble is issued. The following cycle accepts with ex_op2=mem_data.
- ex_ready=0 for 3 cycles while id_valid=1 → ex_* held constant, id_ready=0, no beat lost.
- flush asserted during a load-use stall → next cycle ex_valid=0, FSM=RUN, and the stalled instruction is accepted on re-present.
- Without OPERAND_FETCH_FWD_EN: ALU write rd=9 followed by use of rs1=9 → bubbles until rd=9 leaves MEM, then ex_op1=wb_data.

Source files
------------

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Types and constants shared by the pipelined RISC-V core. The operand fetch
// stage and its bypass muxes use them.
//   REG_ADDR_W  width of a register index
//   REG_ZERO    index of the hard-wired zero register
//   fwd_sel_t   source chosen for one operand
//   of_state_t  operand fetch stage state
//   src_hit()   true when a nonzero destination index matches either source
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_MEM,
        FWD_WB,
        FWD_ZERO
    } fwd_sel_t;

    typedef enum logic {
        OF_RUN,
        OF_STALL
    } of_state_t;

    // Writes to x0 are discarded, so they never create a dependency.
    function automatic logic src_hit(
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] rs1,
        input logic [REG_ADDR_W-1:0] rs2
    );
        return (rd != REG_ZERO) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/operand_bypass_mux.sv
// -----------------------------------------------------------------------------
// operand_bypass_mux
// Resolves one source operand. Sources are listed from highest to lowest
// priority:
//   1. x0, which always reads as zero
//   2. the MEM-stage result (only when OPERAND_FETCH_FWD_EN is defined)
//   3. the WB-stage result
//   4. the register-file read data
// The WB bypass is always present. The register file writes on the same edge
// that samples this operand, so its combinational read data is one write stale.
// Ports:
//   idx                                  source register index
//   rf_val                               register-file read data for idx
//   mem_rd / mem_regwrite / mem_data     MEM-stage result
//   wb_rd  / wb_regwrite  / wb_data      WB-stage result
//   val                                  resolved operand
// Macro: OPERAND_FETCH_FWD_EN enables the MEM bypass.
// -----------------------------------------------------------------------------
module operand_bypass_mux
    import riscv_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [REG_ADDR_W-1:0] idx,
    input  logic [N-1:0]          rf_val,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_regwrite,
    input  logic [N-1:0]          mem_data,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_regwrite,
    input  logic [N-1:0]          wb_data,
    output logic [N-1:0]          val
);

    fwd_sel_t sel;

    always_comb begin
        sel = FWD_RF;
        if (idx == REG_ZERO) begin
            sel = FWD_ZERO;
        end
`ifdef OPERAND_FETCH_FWD_EN
        else if (mem_regwrite && (mem_rd == idx)) begin
            sel = FWD_MEM;
        end
`endif
        else if (wb_regwrite && (wb_rd == idx)) begin
            sel = FWD_WB;
        end
    end

    always_comb begin
        val = rf_val;
        case (sel)
            FWD_ZERO: val = '0;
            FWD_MEM:  val = mem_data;
            FWD_WB:   val = wb_data;
            default:  val = rf_val;
        endcase
    end

`ifndef OPERAND_FETCH_FWD_EN
    // This build does not forward from MEM, so these inputs are not used.
    logic unused_mem;
    assign unused_mem = ^{mem_rd, mem_regwrite, mem_data};
`endif

endmodule

// File: rtl/operand_fetch.sv
// -----------------------------------------------------------------------------
// operand_fetch
// Decode-to-execute operand stage.
//   - Drives the register-file read addresses.
//   - Resolves RAW hazards by bypassing results or by stalling.
//   - Presents the operands to execute through one registered valid/ready slot.
// Ports:
//   clk, rst (asynchronous, active low)
//   id_*                          decode beat: valid/ready, rs1/rs2/rd,
//                                 regwrite, memread, imm
//   rf_src1/2, rf_out1/2          register-file read address and read data
//   mem_* / wb_*                  MEM and WB stage results, used for bypass
//   flush                         squashes the slot on the next edge
//   ex_valid/ex_ready, ex_*       execute slot: operands, immediate, control
// Macro: OPERAND_FETCH_FWD_EN
//   Defined: MEM/WB bypass. A load-use hazard costs a single bubble, handled
//     by the STALL state.
//   Undefined: WB bypass only. The stage interlocks on any pending write in
//     the EX slot or in MEM, and inserts one bubble per stalled cycle.
// -----------------------------------------------------------------------------
module operand_fetch
    import riscv_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic [N-1:0]          id_imm,
    output logic [REG_ADDR_W-1:0] rf_src1,
    output logic [REG_ADDR_W-1:0] rf_src2,
    input  logic [N-1:0]          rf_out1,
    input  logic [N-1:0]          rf_out2,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_regwrite,
    input  logic [N-1:0]          mem_data,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_regwrite,
    input  logic [N-1:0]          wb_data,
    input  logic                  flush,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [N-1:0]          ex_op1,
    output logic [N-1:0]          ex_op2,
    output logic [N-1:0]          ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_regwrite,
    output logic                  ex_memread
);

    // ---------------------------------------------------------------- state
    of_state_t             state_reg, state_next;
    logic                  valid_reg, valid_next;
    logic [N-1:0]          op1_reg, op1_next;
    logic [N-1:0]          op2_reg, op2_next;
    logic [N-1:0]          imm_reg, imm_next;
    logic [REG_ADDR_W-1:0] rd_reg, rd_next;
    logic                  regwrite_reg, regwrite_next;
    logic                  memread_reg, memread_next;

    // ------------------------------------------------- register-file read
    assign rf_src1 = id_rs1;
    assign rf_src2 = id_rs2;

    // -------------------------------------------------- operand bypassing
    logic [1:0][REG_ADDR_W-1:0] src_idx;
    logic [1:0][N-1:0]          src_rf;
    logic [1:0][N-1:0]          src_val;

    assign src_idx = {id_rs2, id_rs1};
    assign src_rf  = {rf_out2, rf_out1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bypass
            operand_bypass_mux #(
                .N (N)
            ) u_mux (
                .idx          (src_idx[gi]),
                .rf_val       (src_rf[gi]),
                .mem_rd       (mem_rd),
                .mem_regwrite (mem_regwrite),
                .mem_data     (mem_data),
                .wb_rd        (wb_rd),
                .wb_regwrite  (wb_regwrite),
                .wb_data      (wb_data),
                .val          (src_val[gi])
            );
        end
    endgenerate

    // ----------------------------------------------------- hazard detection
    logic hazard;
    logic advance;

`ifdef OPERAND_FETCH_FWD_EN
    // Only a load in EX cannot be bypassed yet, because its data arrives in MEM.
    assign hazard = id_valid && valid_reg && memread_reg
                    && src_hit(rd_reg, id_rs1, id_rs2);
`else
    // Without the MEM bypass, a result is readable only once it reaches WB.
    assign hazard = id_valid
                    && ((valid_reg && regwrite_reg && src_hit(rd_reg, id_rs1, id_rs2))
                        || (mem_regwrite && src_hit(mem_rd, id_rs1, id_rs2)));
`endif

    assign advance  = !valid_reg || ex_ready;
    assign id_ready = advance && !hazard && !flush;

    // ------------------------------------------------- next-state / slot
    always_comb begin
        state_next    = state_reg;
        valid_next    = valid_reg;
        op1_next      = op1_reg;
        op2_next      = op2_reg;
        imm_next      = imm_reg;
        rd_next       = rd_reg;
        regwrite_next = regwrite_reg;
        memread_next  = memread_reg;

        if (flush) begin
            // Squash: the slot becomes a bubble whatever else is happening.
            state_next    = OF_RUN;
            valid_next    = 1'b0;
            rd_next       = REG_ZERO;
            regwrite_next = 1'b0;
            memread_next  = 1'b0;
        end else begin
            case (state_reg)
                OF_RUN: begin
                    if (advance) begin
                        op1_next = src_val[0];
                        op2_next = src_val[1];
                        imm_next = id_imm;
                        if (hazard) begin
                            valid_next    = 1'b0;
                            rd_next       = REG_ZERO;
                            regwrite_next = 1'b0;
                            memread_next  = 1'b0;
`ifdef OPERAND_FETCH_FWD_EN
                            state_next    = OF_STALL;
`endif
                        end else begin
                            valid_next    = id_valid;
                            rd_next       = id_valid ? id_rd : REG_ZERO;
                            regwrite_next = id_valid && id_regwrite;
                            memread_next  = id_valid && id_memread;
                        end
                    end
                end
                OF_STALL: begin
                    // The slot holds a bubble and the load is now in MEM, so
                    // its result is bypassed and the accept is unconditional.
                    state_next    = OF_RUN;
                    op1_next      = src_val[0];
                    op2_next      = src_val[1];
                    imm_next      = id_imm;
                    valid_next    = id_valid;
                    rd_next       = id_valid ? id_rd : REG_ZERO;
                    regwrite_next = id_valid && id_regwrite;
                    memread_next  = id_valid && id_memread;
                end
                default: begin
                    state_next = OF_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= OF_RUN;
            valid_reg    <= 1'b0;
            op1_reg      <= '0;
            op2_reg      <= '0;
            imm_reg      <= '0;
            rd_reg       <= REG_ZERO;
            regwrite_reg <= 1'b0;
            memread_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            valid_reg    <= valid_next;
            op1_reg      <= op1_next;
            op2_reg      <= op2_next;
            imm_reg      <= imm_next;
            rd_reg       <= rd_next;
            regwrite_reg <= regwrite_next;
            memread_reg  <= memread_next;
        end
    end

    assign ex_valid    = valid_reg;
    assign ex_op1      = op1_reg;
    assign ex_op2      = op2_reg;
    assign ex_imm      = imm_reg;
    assign ex_rd       = rd_reg;
    assign ex_regwrite = regwrite_reg;
    assign ex_memread  = memread_reg;

endmodule

// File: tb/tb_operand_fetch.sv
// -----------------------------------------------------------------------------
// tb_operand_fetch
// Directed test of operand_fetch. Every expected value is computed by hand.
// Tests that need the MEM bypass compile only when OPERAND_FETCH_FWD_EN is
// defined. The full-interlock tests compile only when it is undefined.
// -----------------------------------------------------------------------------
module tb_operand_fetch;
    import riscv_pkg::*;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic        id_ready;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_regwrite, id_memread;
    logic [31:0] id_imm;
    logic [4:0]  rf_src1, rf_src2;
    logic [31:0] rf_out1, rf_out2;
    logic [4:0]  mem_rd;
    logic        mem_regwrite;
    logic [31:0] mem_data;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_op1, ex_op2, ex_imm;
    logic [4:0]  ex_rd;
    logic        ex_regwrite, ex_memread;

    int n_checks = 0;
    int n_fail   = 0;

    operand_fetch #(.N(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_regwrite  (id_regwrite),
        .id_memread   (id_memread),
        .id_imm       (id_imm),
        .rf_src1      (rf_src1),
        .rf_src2      (rf_src2),
        .rf_out1      (rf_out1),
        .rf_out2      (rf_out2),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .mem_data     (mem_data),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .wb_data      (wb_data),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_op1       (ex_op1),
        .ex_op2       (ex_op2),
        .ex_imm       (ex_imm),
        .ex_rd        (ex_rd),
        .ex_regwrite  (ex_regwrite),
        .ex_memread   (ex_memread)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    // Inputs change 1 time unit after the rising edge. Checks run 2 time
    // units after that, well clear of the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic present(input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic rw, input logic mr,
                           input logic [31:0] imm, input logic [31:0] r1,
                           input logic [31:0] r2);
        id_valid    = 1'b1;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_regwrite = rw;
        id_memread  = mr;
        id_imm      = imm;
        rf_out1     = r1;
        rf_out2     = r2;
    endtask

    initial begin
        rst = 1'b0;
        id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_regwrite = 1'b0; id_memread = 1'b0; id_imm = '0;
        rf_out1 = 32'hDEAD_0001; rf_out2 = 32'hDEAD_0002;
        mem_rd = '0; mem_regwrite = 1'b0; mem_data = '0;
        wb_rd = '0; wb_regwrite = 1'b0; wb_data = '0;
        flush = 1'b0; ex_ready = 1'b1;

        // ---- reset state
        #3;
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_ex_op1", ex_op1, 32'd0);
        check("rst_ex_op2", ex_op2, 32'd0);
        check("rst_ex_imm", ex_imm, 32'd0);
        check("rst_ex_rd", 32'(ex_rd), 32'd0);
        check("rst_ex_ctrl", 32'({ex_regwrite, ex_memread}), 32'd0);
        rst = 1'b1;
        tick();
        check("idle_ex_valid", 32'(ex_valid), 32'd0);

        // ---- basic accept with register-file operands
        present(5'd3, 5'd4, 5'd10, 1'b1, 1'b0, 32'h123, 32'h11, 32'h22);
        settle();
        check("rf_src1", 32'(rf_src1), 32'd3);
        check("rf_src2", 32'(rf_src2), 32'd4);
        check("basic_id_ready", 32'(id_ready), 32'd1);
        tick();
        check("basic_ex_valid", 32'(ex_valid), 32'd1);
        check("basic_ex_op1", ex_op1, 32'h11);
        check("basic_ex_op2", ex_op2, 32'h22);
        check("basic_ex_imm", ex_imm, 32'h123);
        check("basic_ex_rd", 32'(ex_rd), 32'd10);
        check("basic_ex_regwrite", 32'(ex_regwrite), 32'd1);

        // ---- WB bypass beats the stale register-file read
        wb_rd = 5'd5; wb_regwrite = 1'b1; wb_data = 32'hBB;
        present(5'd5, 5'd6, 5'd0, 1'b0, 1'b0, 32'h0, 32'h55, 32'h66);
        settle();
        check("wb_id_ready", 32'(id_ready), 32'd1);
        tick();
        check("wb_ex_op1", ex_op1, 32'hBB);
        check("wb_ex_op2", ex_op2, 32'h66);

        // ---- x0 always reads as zero, even against matching bypasses
        wb_rd = 5'd0; mem_rd = 5'd0; mem_regwrite = 1'b1; mem_data = 32'hAA;
        present(5'd0, 5'd6, 5'd0, 1'b0, 1'b0, 32'h0, 32'h77, 32'h66);
        tick();
        check("zero_ex_op1", ex_op1, 32'h0);
        mem_regwrite = 1'b0; wb_regwrite = 1'b0;

`ifdef OPERAND_FETCH_FWD_EN
        // ---- MEM has priority over WB, then WB alone
        mem_rd = 5'd5; mem_regwrite = 1'b1; mem_data = 32'hAA;
        wb_rd = 5'd5; wb_regwrite = 1'b1; wb_data = 32'hBB;
        present(5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h55, 32'h0);
        tick();
        check("memwb_ex_op1", ex_op1, 32'hAA);
        mem_regwrite = 1'b0;
        tick();
        check("wbonly_ex_op1", ex_op1, 32'hBB);
        wb_regwrite = 1'b0;
`endif

        // ---- back-pressure: slot held, nothing lost
        present(5'd13, 5'd14, 5'd12, 1'b1, 1'b0, 32'h5A, 32'h130, 32'h140);
        tick();
        check("bp_a_ex_op1", ex_op1, 32'h130);
        ex_ready = 1'b0;
        present(5'd15, 5'd16, 5'd17, 1'b1, 1'b0, 32'h6B, 32'h150, 32'h160);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("bp_id_ready", 32'(id_ready), 32'd0);
            check("bp_ex_valid", 32'(ex_valid), 32'd1);
            check("bp_ex_op1", ex_op1, 32'h130);
            check("bp_ex_rd", 32'(ex_rd), 32'd12);
            check("bp_ex_imm", ex_imm, 32'h5A);
            tick();
        end
        ex_ready = 1'b1;
        settle();
        check("bp_release_id_ready", 32'(id_ready), 32'd1);
        tick();
        check("bp_b_ex_op1", ex_op1, 32'h150);
        check("bp_b_ex_op2", ex_op2, 32'h160);
        check("bp_b_ex_rd", 32'(ex_rd), 32'd17);
        id_valid = 1'b0;
        tick();
        check("drain_ex_valid", 32'(ex_valid), 32'd0);

`ifdef OPERAND_FETCH_FWD_EN
        // ---- load-use: one bubble, then the load result comes from MEM
        present(5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 32'h0, 32'h1, 32'h2);
        tick();
        check("lu_ex_memread", 32'(ex_memread), 32'd1);
        present(5'd8, 5'd7, 5'd20, 1'b1, 1'b0, 32'h0, 32'h88, 32'h99);
        settle();
        check("lu_id_ready", 32'(id_ready), 32'd0);
        tick();
        check("lu_bubble_valid", 32'(ex_valid), 32'd0);
        check("lu_bubble_rd", 32'(ex_rd), 32'd0);
        check("lu_bubble_ctrl", 32'({ex_regwrite, ex_memread}), 32'd0);
        check("lu_state_stall", 32'(dut.state_reg), 32'(OF_STALL));
        mem_rd = 5'd7; mem_regwrite = 1'b1; mem_data = 32'hC0DE;
        settle();
        check("lu_accept_id_ready", 32'(id_ready), 32'd1);
        tick();
        check("lu_ex_valid", 32'(ex_valid), 32'd1);
        check("lu_ex_op1", ex_op1, 32'h88);
        check("lu_ex_op2", ex_op2, 32'hC0DE);
        mem_regwrite = 1'b0;
        id_valid = 1'b0;
        tick();

        // ---- flush during a load-use stall: flush wins, no STALL state
        present(5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 32'h0, 32'h1, 32'h2);
        tick();
        present(5'd7, 5'd3, 5'd21, 1'b1, 1'b0, 32'h0, 32'h70, 32'h30);
        flush = 1'b1;
        settle();
        check("fl_id_ready", 32'(id_ready), 32'd0);
        tick();
        flush = 1'b0;
        check("fl_ex_valid", 32'(ex_valid), 32'd0);
        check("fl_state_run", 32'(dut.state_reg), 32'(OF_RUN));
        settle();
        check("fl_re_id_ready", 32'(id_ready), 32'd1);
        tick();
        check("fl_re_ex_valid", 32'(ex_valid), 32'd1);
        check("fl_re_ex_op1", ex_op1, 32'h70);
        check("fl_re_ex_rd", 32'(ex_rd), 32'd21);
        id_valid = 1'b0;
        tick();

        // ---- ALU result followed by its use: no stall with forwarding
        present(5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 32'h0, 32'h1, 32'h2);
        tick();
        present(5'd9, 5'd0, 5'd22, 1'b1, 1'b0, 32'h0, 32'h1, 32'h0);
        settle();
        check("alu_use_id_ready", 32'(id_ready), 32'd1);
        tick();
        check("alu_use_ex_rd", 32'(ex_rd), 32'd22);
`else
        // ---- full interlock: bubbles until rd=9 leaves MEM
        present(5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 32'h0, 32'h1, 32'h2);
        tick();
        present(5'd9, 5'd2, 5'd22, 1'b1, 1'b0, 32'h0, 32'h1, 32'h2);
        settle();
        check("il_ex_id_ready", 32'(id_ready), 32'd0);
        tick();
        check("il_bubble1_valid", 32'(ex_valid), 32'd0);
        check("il_bubble1_rd", 32'(ex_rd), 32'd0);
        mem_rd = 5'd9; mem_regwrite = 1'b1; mem_data = 32'hBAD;
        settle();
        check("il_mem_id_ready", 32'(id_ready), 32'd0);
        tick();
        check("il_bubble2_valid", 32'(ex_valid), 32'd0);
        mem_regwrite = 1'b0;
        wb_rd = 5'd9; wb_regwrite = 1'b1; wb_data = 32'h900D;
        settle();
        check("il_wb_id_ready", 32'(id_ready), 32'd1);
        tick();
        check("il_ex_valid", 32'(ex_valid), 32'd1);
        check("il_ex_op1", ex_op1, 32'h900D);
        check("il_ex_rd", 32'(ex_rd), 32'd22);
        wb_regwrite = 1'b0;
`endif

        // ---- asynchronous reset drops the slot immediately
        id_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("arst_ex_valid", 32'(ex_valid), 32'd0);
        check("arst_ex_rd", 32'(ex_rd), 32'd0);
        check("arst_ex_op1", ex_op1, 32'd0);
        rst = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
